n_input_gate_bank: RTL

- Parametrised successor to the fixed single 8-input NAND IP for the 74-series catalogue.
- Provides CHANNELS independent WIDTH-input gates with a runtime-selectable function and a per-input enable mask.
- Outputs are registered through a PIPE-deep valid-tagged pipeline. Each channel has a saturating rising-edge event counter.
- Sits between switch/counter logic and display/decode logic in the digital-clock design.

---
 rtl/gate_bank_pkg.sv | 41 ++++
 rtl/gate_channel.sv | 116 +++++++++++
 rtl/n_input_gate_bank.sv | 74 +++++++
 3 files changed

// File: rtl/gate_bank_pkg.sv
// -----------------------------------------------------------------------------
// gate_bank_pkg
// Shared definitions for the n_input_gate_bank gate array:
//   gate_fn_e     - gate function codes (NAND, AND, NOR, OR, XOR, XNOR)
//   DEFAULT_FUNC  - function used for the unassigned codes 6 and 7
//   canon_func()  - maps a raw 3-bit function code onto gate_fn_e
//   identity_bit()- value a masked-off input takes so it cannot affect the
//                   reduction of the selected function
// No ports (package).
// -----------------------------------------------------------------------------
package gate_bank_pkg;

    typedef enum logic [2:0] {
        FN_NAND = 3'd0,
        FN_AND  = 3'd1,
        FN_NOR  = 3'd2,
        FN_OR   = 3'd3,
        FN_XOR  = 3'd4,
        FN_XNOR = 3'd5
    } gate_fn_e;

    // Codes 6 and 7 fall back to NAND, the function of the original fixed IP.
    localparam gate_fn_e DEFAULT_FUNC = FN_NAND;

    function automatic gate_fn_e canon_func(input logic [2:0] code);
        if (code > 3'd5) begin
            canon_func = DEFAULT_FUNC;
        end else begin
            canon_func = gate_fn_e'(code);
        end
    endfunction

    // AND-family reductions ignore a 1, OR/XOR-family reductions ignore a 0.
    function automatic logic identity_bit(input gate_fn_e fn);
        case (fn)
            FN_NAND, FN_AND: identity_bit = 1'b1;
            default:         identity_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gate_channel.sv
// -----------------------------------------------------------------------------
// gate_channel
// One channel of the gate bank: masked WIDTH-input reduction, PIPE-deep result
// registers that load only when their incoming stage is valid, and a
// saturating rising-edge counter on the channel's valid output stream.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   i_in_valid        - sample on i_func/i_mask/i_din is accepted this cycle
//   i_stage_vld       - shared valid bits of pipeline stages 0..PIPE-1
//   i_func            - raw 3-bit gate function code
//   i_mask            - per-input enable (1 = input used)
//   i_din             - this channel's WIDTH inputs
//   i_cnt_clr         - synchronous clear of the edge counter
//   o_y               - last valid gate result
//   o_edge_cnt        - saturating count of 0->1 transitions of valid results
// -----------------------------------------------------------------------------
module gate_channel
    import gate_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PIPE  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    input  logic [PIPE-1:0]  i_stage_vld,
    input  logic [2:0]       i_func,
    input  logic [WIDTH-1:0] i_mask,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_cnt_clr,
    output logic             o_y,
    output logic [CNT_W-1:0] o_edge_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    gate_fn_e         w_fn;
    logic             w_ident;
    logic [WIDTH-1:0] w_masked;
    logic             w_result;
    logic             w_y;
    logic             w_out_vld;

    logic [PIPE-1:0]  r_data;
    logic             r_prev_y;
    logic [CNT_W-1:0] r_cnt;

    // The function is resolved at capture time, so func and mask only need to
    // be valid alongside din; later func changes cannot reach this sample.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        w_result = 1'b0;
        w_fn     = canon_func(i_func);
        w_ident  = identity_bit(w_fn);
        for (int k = 0; k < WIDTH; k++) begin
            w_masked[k] = i_mask[k] ? i_din[k] : w_ident;
        end
        case (w_fn)
            FN_AND:  w_result =  (&w_masked);
            FN_NOR:  w_result = ~(|w_masked);
            FN_OR:   w_result =  (|w_masked);
            FN_XOR:  w_result =  (^w_masked);
            FN_XNOR: w_result = ~(^w_masked);
            default: w_result = ~(&w_masked);
        endcase
    end

    // Each stage loads only when a valid sample enters it, so the output
    // holds the last valid result across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the pipeline registers are reset (not left free-running like a
        // RAM) because y must read 0 straight out of reset.
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the value
            // its predecessor held before this edge.
            if (i_in_valid) begin
                r_data[0] <= w_result;
            end
            for (int k = 1; k < PIPE; k++) begin
                if (i_stage_vld[k-1]) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    assign w_y       = r_data[PIPE-1];
    assign w_out_vld = i_stage_vld[PIPE-1];

    // History follows valid results only; a clear touches the count alone and
    // wins over an increment landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_y <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_out_vld) begin
                r_prev_y <= w_y;
            end
            if (i_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_out_vld && !r_prev_y && w_y && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_y        = w_y;
    assign o_edge_cnt = r_cnt;

endmodule

// File: rtl/n_input_gate_bank.sv
// -----------------------------------------------------------------------------
// n_input_gate_bank
// CHANNELS independent WIDTH-input gates with a runtime-selectable function,
// a shared per-input enable mask, a PIPE-deep valid-tagged output pipeline and
// a saturating rising-edge counter per channel.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - din/func/mask valid this cycle
//   func        - 0 NAND, 1 AND, 2 NOR, 3 OR, 4 XOR, 5 XNOR, 6/7 NAND
//   mask        - per-input enable shared by all channels (1 = used)
//   din         - channel c inputs at din[c*WIDTH +: WIDTH]
//   cnt_clr     - synchronous clear of all edge counters
//   out_valid   - y carries a new result this cycle
//   y           - gate outputs, bit c = channel c
//   edge_cnt    - channel c counter at edge_cnt[c*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module n_input_gate_bank
    import gate_bank_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8,
    parameter int PIPE     = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [2:0]                func,
    input  logic [WIDTH-1:0]          mask,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      cnt_clr,
    output logic                      out_valid,
    output logic [CHANNELS-1:0]       y,
    output logic [CHANNELS*CNT_W-1:0] edge_cnt
);

    // Valid tags are common to every channel, so one shift register here
    // steers the data stages of all channels. func and mask are consumed when
    // the sample is accepted, which is how they travel with it.
    logic [PIPE-1:0] r_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= in_valid;
            for (int k = 1; k < PIPE; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    assign out_valid = r_vld[PIPE-1];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        gate_channel #(
            .WIDTH (WIDTH),
            .PIPE  (PIPE),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_in_valid  (in_valid),
            .i_stage_vld (r_vld),
            .i_func      (func),
            .i_mask      (mask),
            .i_din       (din[c*WIDTH +: WIDTH]),
            .i_cnt_clr   (cnt_clr),
            .o_y         (y[c]),
            .o_edge_cnt  (edge_cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule
